// File: rtl/sequencer_cpu_jtag_scan_master.sv
// Virtual-JTAG initiator: runs IR+DR scan transactions into the sequencer CPU debug module
// from a valid/ready command port and returns the captured DR contents.
module sequencer_cpu_jtag_scan_master #(
    parameter int TCK_DIV = 2,
    parameter int DR_LEN  = 38,
    parameter int IR_LEN  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IR_LEN-1:0] cmd_ir,
    input  logic              cmd_skip_ir,
    input  logic [DR_LEN-1:0] cmd_dr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_LEN-1:0] rsp_dr,
    output logic [IR_LEN-1:0] rsp_ir_out,
    output logic              vji_tck,
    output logic              vji_tdi,
    input  logic              vji_tdo,
    output logic [IR_LEN-1:0] vji_ir_in,
    input  logic [IR_LEN-1:0] vji_ir_out,
    output logic              vji_uir,
    output logic              vji_cdr,
    output logic              vji_sdr,
    output logic              vji_udr,
    output logic              vji_rti
);
    localparam int BW = (DR_LEN > 1) ? $clog2(DR_LEN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_phase;
    logic                r_tck;
    logic                r_pend;
    logic                r_skip;
    logic [IR_LEN-1:0]   r_ir;
    logic [IR_LEN-1:0]   r_ir_in;
    logic [DR_LEN-1:0]   r_dr;
    logic [DR_LEN-1:0]   r_sh;
    logic [DR_LEN-1:0]   r_cap;
    logic [DR_LEN-1:0]   r_rsp_dr;
    logic [IR_LEN-1:0]   r_rsp_ir_out;
    logic [BW-1:0]       r_bit;
    logic                w_wrap;
    logic                w_rise;
    logic                w_fall;

    assign w_wrap = (r_phase == 8'(TCK_DIV - 1));
    assign w_rise = w_wrap & ~r_tck;
    assign w_fall = w_wrap & r_tck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every scan step advances on a tck fall; only the response handshake ignores tck.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (r_pend && w_fall) w_next = r_skip ? S_CDR : S_UIR;
            S_UIR:  if (w_fall) w_next = S_CDR;
            S_CDR:  if (w_fall) w_next = S_SDR;
            S_SDR:  if (w_fall && r_bit == BW'(DR_LEN - 1)) w_next = S_UDR;
            S_UDR:  if (w_fall) w_next = S_RESP;
            S_RESP: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE) && !r_pend;
        rsp_valid = (r_state == S_RESP);
        vji_rti   = (r_state == S_IDLE);
        vji_uir   = (r_state == S_UIR);
        vji_cdr   = (r_state == S_CDR);
        vji_sdr   = (r_state == S_SDR);
        vji_udr   = (r_state == S_UDR);
        vji_tdi   = 1'b0;
        if (r_state == S_CDR || r_state == S_SDR) begin
            vji_tdi = r_sh[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase      <= '0;
            r_tck        <= 1'b0;
            r_pend       <= 1'b0;
            r_skip       <= 1'b0;
            r_ir         <= '0;
            r_ir_in      <= '0;
            r_dr         <= '0;
            r_sh         <= '0;
            r_cap        <= '0;
            r_rsp_dr     <= '0;
            r_rsp_ir_out <= '0;
            r_bit        <= '0;
        end else begin
            r_phase <= w_wrap ? 8'd0 : r_phase + 8'd1;
            if (w_wrap) begin
                r_tck <= ~r_tck;
            end
            if (cmd_valid && cmd_ready) begin
                r_pend <= 1'b1;
                r_ir   <= cmd_ir;
                r_skip <= cmd_skip_ir;
                r_dr   <= cmd_dr;
            end
            if (r_state == S_IDLE && r_pend && w_fall) begin
                r_pend <= 1'b0;
            end
            if (w_next == S_UIR && r_state != S_UIR) begin
                r_ir_in <= r_ir;
            end
            if (r_state == S_UIR && w_rise) begin
                r_rsp_ir_out <= vji_ir_out;
            end
            if (w_next == S_CDR && r_state != S_CDR) begin
                r_sh <= r_dr;
            end
            if (w_next == S_SDR && r_state != S_SDR) begin
                r_bit <= '0;
            end
            // tdo is sampled on the rise and lands in the MSB, so the first bit ends at bit 0.
            if (r_state == S_SDR) begin
                if (w_rise) begin
                    r_cap <= {vji_tdo, r_cap[DR_LEN-1:1]};
                end
                if (w_fall) begin
                    r_sh  <= r_sh >> 1;
                    r_bit <= r_bit + BW'(1);
                end
            end
            if (r_state == S_UDR && w_fall) begin
                r_rsp_dr <= r_cap;
            end
        end
    end

    assign vji_tck    = r_tck;
    assign vji_ir_in  = r_ir_in;
    assign rsp_dr     = r_rsp_dr;
    assign rsp_ir_out = r_rsp_ir_out;

endmodule

// File: tb/tb_sequencer_cpu_jtag_scan_master.sv
// Scoreboarded bench: a loopback debug-module shift register on tck, stimulus pushes expected
// responses, and a monitor pops and compares whenever a response is handed over.
module tb_sequencer_cpu_jtag_scan_master;
    localparam int TD  = 2;
    localparam int DL  = 38;
    localparam int IL  = 2;
    localparam int PER = 2 * TD;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [IL-1:0] cmd_ir = '0;
    logic          cmd_skip_ir = 1'b0;
    logic [DL-1:0] cmd_dr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DL-1:0] rsp_dr;
    logic [IL-1:0] rsp_ir_out;
    logic          vji_tck, vji_tdi, vji_tdo;
    logic [IL-1:0] vji_ir_in;
    logic [IL-1:0] vji_ir_out = '0;
    logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    sequencer_cpu_jtag_scan_master #(.TCK_DIV(TD), .DR_LEN(DL), .IR_LEN(IL)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
        .cmd_skip_ir(cmd_skip_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Loopback debug-module data register: shifts on tck rise while in SDR.
    logic [DL-1:0] dev_sr = '0;
    logic [DL-1:0] dev_preset = '0;
    logic          dev_load = 1'b0;
    int            sdr_rises = 0;
    always @(posedge vji_tck or posedge dev_load) begin
        if (dev_load) begin
            dev_sr <= dev_preset;
        end else if (vji_sdr) begin
            dev_sr    <= {vji_tdi, dev_sr[DL-1:1]};
            sdr_rises <= sdr_rises + 1;
        end
    end
    assign vji_tdo = dev_sr[0];

    typedef struct {
        logic [DL-1:0] dr;
        logic [DL-1:0] dev;
        logic [IL-1:0] iro;
        logic [IL-1:0] iri;
        int            uir;
        int            periods;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model of the debug-visible state.
    logic [DL-1:0] m_dr;
    logic [IL-1:0] m_iro, m_iri;

    int acc_cyc = 0, fall_cyc = 0, uir_cnt = 0, sdr_base = 0, resp_done = 0;
    bit waiting_fall = 0, prev_tck = 0, prev_rv = 0;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_tck && !vji_tck && waiting_fall && cyc > acc_cyc) begin
                fall_cyc     = cyc;
                waiting_fall = 0;
            end
            if (vji_uir) uir_cnt++;
            if (rsp_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid rose with no scan outstanding");
                end else begin
                    check("latency_after_align", 64'(cyc - fall_cyc), 64'(exp_q[0].periods * PER));
                end
            end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_dr", 64'(rsp_dr), 64'(e.dr));
                check("rsp_ir_out", 64'(rsp_ir_out), 64'(e.iro));
                check("ir_in", 64'(vji_ir_in), 64'(e.iri));
                check("uir_clks", 64'(uir_cnt), 64'(e.uir));
                check("sdr_periods", 64'(sdr_rises - sdr_base), 64'(DL));
                check("model_sr_end", 64'(dev_sr), 64'(e.dev));
                resp_done++;
            end
            if (cmd_valid && cmd_ready) begin
                acc_cyc      = cyc + 1;
                waiting_fall = 1;
                uir_cnt      = 0;
                sdr_base     = sdr_rises;
            end
            prev_tck = vji_tck;
            prev_rv  = rsp_valid;
        end
    endtask

    task automatic preset_dev(input logic [DL-1:0] v);
        dev_preset = v;
        dev_load   = 1'b1;
        #1 dev_load = 1'b0;
        m_dr = v;
    endtask

    task automatic issue(input logic [IL-1:0] ir, input logic skip, input logic [DL-1:0] dr,
                         input logic [IL-1:0] iro);
        exp_t e;
        int t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (!cmd_ready && t < 500);
        check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        vji_ir_out  = iro;
        cmd_ir      = ir;
        cmd_skip_ir = skip;
        cmd_dr      = dr;
        cmd_valid   = 1'b1;
        e.dr      = m_dr;
        e.dev     = dr;
        e.iro     = skip ? m_iro : iro;
        e.iri     = skip ? m_iri : ir;
        e.uir     = skip ? 0 : PER;
        e.periods = skip ? DL + 2 : DL + 3;
        exp_q.push_back(e);
        m_dr  = dr;
        m_iro = e.iro;
        m_iri = e.iri;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
        cmd_dr      = DL'({$urandom, $urandom});
        cmd_ir      = ~ir;
        cmd_skip_ir = ~skip;
    endtask

    task automatic do_scan(input logic [IL-1:0] ir, input logic skip, input logic [DL-1:0] dr,
                           input logic [IL-1:0] iro, input bit hold);
        int target = resp_done + 1;
        int t = 0;
        logic [DL-1:0] held;
        if (hold) rsp_ready = 1'b0;
        issue(ir, skip, dr, iro);
        if (hold) begin
            while (!rsp_valid && t < 400) begin
                @(posedge clk); #1; t++;
            end
            check("bp_rsp_valid_wait", 64'(rsp_valid), 64'(1));
            held = rsp_dr;
            for (int i = 0; i < 50; i++) begin
                @(posedge clk); #1;
                if (i % 10 == 0 || rsp_valid !== 1'b1 || rsp_dr !== held || cmd_ready !== 1'b0) begin
                    check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
                    check("bp_rsp_dr_stable", 64'(rsp_dr), 64'(held));
                    check("bp_cmd_ready", 64'(cmd_ready), 64'(0));
                    check("bp_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'(0));
                end
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            check("bp_release_cmd_ready", 64'(cmd_ready), 64'(1));
            check("bp_release_rti", 64'(vji_rti), 64'(1));
        end
        t = 0;
        while (resp_done < target && t < 500) begin
            @(posedge clk); #1; t++;
        end
        check("scan_complete", 64'(resp_done >= target), 64'(1));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tck"}, 64'(vji_tck), 64'(0));
        check({tag, "_tdi"}, 64'(vji_tdi), 64'(0));
        check({tag, "_ir_in"}, 64'(vji_ir_in), 64'(0));
        check({tag, "_strobes"}, 64'({vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'(0));
        check({tag, "_rti"}, 64'(vji_rti), 64'(1));
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_dr"}, 64'(rsp_dr), 64'(0));
        check({tag, "_rsp_ir_out"}, 64'(rsp_ir_out), 64'(0));
    endtask

    initial begin
        bit tog [8];
        logic prev;
        int t;
        m_iro = '0;
        m_iri = '0;
        fork
            monitor();
        join_none
        preset_dev(38'h15_1234_5678);
        repeat (4) @(posedge clk);
        #1 check_reset_state("reset");
        reset_n = 1'b1;
        prev = vji_tck;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            tog[i] = (vji_tck != prev);
            prev   = vji_tck;
        end
        for (int i = 1; i < 8; i++) check("tck_every_2clk", 64'(tog[i] ^ tog[i-1]), 64'(1));

        do_scan(2'b01, 1'b0, 38'h2A_5A5A_5A5A, 2'b10, 0);
        do_scan(2'b10, 1'b1, 38'h0F_0F0F_0F0F, 2'b01, 0);
        do_scan(2'b10, 1'b0, 38'h3F_FFFF_0001, 2'b11, 0);
        do_scan(2'b11, 1'b0, 38'h01_8000_0001, 2'b00, 1);
        for (int n = 0; n < 6; n++) begin
            do_scan(2'($urandom), ($urandom_range(0, 2) == 0), DL'({$urandom, $urandom}),
                    2'($urandom), 0);
        end

        issue(2'b01, 1'b0, 38'h12_3456_789A, 2'b11);
        t = 0;
        while ((sdr_rises - sdr_base) < 20 && t < 400) begin
            @(posedge clk); #1; t++;
        end
        check("reached_bit20", 64'(sdr_rises - sdr_base), 64'(20));
        reset_n = 1'b0;
        #1;
        check("midreset_tck", 64'(vji_tck), 64'(0));
        check("midreset_sdr", 64'(vji_sdr), 64'(0));
        exp_q.delete();
        m_iro = '0;
        m_iri = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_state("midreset");
        preset_dev(38'h2B_CAFE_F00D);
        @(posedge clk); #1 reset_n = 1'b1;
        do_scan(2'b10, 1'b0, DL'({$urandom, $urandom}), 2'b01, 0);
        do_scan(2'b01, 1'b1, DL'({$urandom, $urandom}), 2'b10, 0);
        repeat (20) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequencer_cpu_jtag_scan_master.md
Name: sequencer_cpu_jtag_scan_master

Overview:
- Synthesizable virtual-JTAG initiator for the sequencer CPU debug module.
- Drives the vji_* strobes and tck/tdi the debug module's tck domain consumes: uir, cdr, sdr, udr, rti, ir_in.
- Runs full IR+DR scan transactions from a valid/ready command port on the system clock and returns captured DR data.
- Used for on-chip self-test of the debug path, and as a bench driver where no sld_virtual_jtag_basic hub exists.

Parameters:
- TCK_DIV, 2, tck half-period in clk cycles (legal 1..255).
- DR_LEN, 38, DR scan length in bits; matches the debug module sr width.
- IR_LEN, 2, virtual IR width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_ir  in  IR_LEN  virtual IR value for this scan.
- cmd_skip_ir  in  1  1 = skip UIR phase and keep current ir_in.
- cmd_dr  in  DR_LEN  data shifted into the debug module, LSB first.
- rsp_valid  out  1  scan result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_dr  out  DR_LEN  bits captured from vji_tdo.
- rsp_ir_out  out  IR_LEN  vji_ir_out sampled during UIR.
- vji_tck  out  1  generated JTAG clock.
- vji_tdi  out  1  serial data to the debug module.
- vji_tdo  in  1  serial data from the debug module.
- vji_ir_in  out  IR_LEN  virtual IR register.
- vji_ir_out  in  IR_LEN  debug-module IR status.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1  virtual JTAG state indications.

Behaviour:
- Reset state (reset_n low, asynchronous):
  - State IDLE; phase counter 0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0.
  - vji_uir/cdr/sdr/udr=0, vji_rti=1.
  - cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir_out=0.
  - Reset mid-scan aborts the scan; no response is produced.
- tck generation:
  - Phase counter counts 0..TCK_DIV-1 every clk; vji_tck toggles on the wrap.
  - tck is free-running after reset and stops only during reset.
  - rise_ev / fall_ev: single-clk internal pulses on the cycle vji_tck goes 1 / 0.
- State machine IDLE -> UIR -> CDR -> SDR -> UDR -> RESP -> IDLE:
  - All transitions except from RESP occur on fall_ev only.
  - Each of UIR, CDR and UDR lasts exactly one tck period.
  - The strobe vji_uir/cdr/sdr/udr is 1 exactly while in the matching state.
  - vji_rti=1 only in IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_ir, cmd_skip_ir and cmd_dr; cmd_ready drops the next clk.
  - At the next fall_ev go to UIR, or to CDR if skip is set.
  - If no command is pending, remain in IDLE.
- UIR:
  - vji_ir_in loads the latched cmd_ir on entry and holds until the next UIR or reset.
  - rsp_ir_out samples vji_ir_out on the rise_ev within UIR.
  - With skip set, rsp_ir_out keeps its previous value.
- CDR:
  - Load the shift register from the latched cmd_dr.
  - vji_tdi = bit 0 from entry.
- SDR:
  - Exactly DR_LEN tck periods, counted by a bit counter 0..DR_LEN-1.
  - At each rise_ev, capture vji_tdo into the capture-register MSB; the capture register shifts right.
  - At each fall_ev, vji_tdi advances to the next cmd_dr bit.
  - After DR_LEN rises the capture register holds the debug module's pre-scan sr, bit0 = first tdo.
  - At the fall_ev following the last rise, go to UDR.
  - vji_tdi returns to 0 outside SDR/CDR.
- UDR: lasts one period; at its end, rsp_dr takes the capture register and the FSM goes to RESP.
- RESP:
  - rsp_valid=1; rsp_dr and rsp_ir_out are stable.
  - On rsp_valid&rsp_ready, go to IDLE on the same clk edge; no tck alignment is required.
  - cmd_ready is 0 in RESP, so a command cannot overlap an unread response.
- Latency, cmd accept to rsp_valid:
  - Full scan: at most 2*TCK_DIV alignment clks + (3+DR_LEN)*2*TCK_DIV clks.
  - With skip set: one fewer tck period.
- TCK_DIV=1: tck toggles every clk, and rise_ev/fall_ev alternate on consecutive clks; behaviour is otherwise identical.
- cmd_dr changes after acceptance do not affect the scan in progress.

Test Plan:
- Reset values: hold reset_n=0 -> all outputs at reset values, vji_rti=1, cmd_ready=1.
  - Release -> vji_tck toggles every 2 clk (TCK_DIV=2).
- Full scan: cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A, loopback tdo = 38-bit model shift register preset to 38'h15_1234_5678.
  - vji_uir high 4 clk, ir_in=01.
  - Exactly 38 sdr tck periods.
  - tdi sequence equals cmd_dr LSB first.
  - rsp_dr=38'h15_1234_5678.
  - Model register ends at 38'h2A_5A5A_5A5A.
- Skip IR: cmd_skip_ir=1, cmd_ir=2'b10 after the full scan above -> no uir pulse, ir_in stays 01, and accept-to-rsp_valid is 4 clk shorter than the full scan.
- IR status capture: vji_ir_out=2'b11 driven during UIR -> rsp_ir_out=11.
- Response backpressure: hold rsp_ready=0 for 50 clk -> rsp_valid and rsp_dr stable, cmd_ready=0, no strobes.
  - Raise rsp_ready -> IDLE next clk, cmd_ready=1.
- Reset mid-SDR: assert reset_n=0 at bit 20 -> tck=0 and vji_sdr=0 immediately, rsp_valid never rises; a new scan then completes correctly.
